udp_rx_pkt_buffer: RTL and testbench

UDP_RX_PKT_BUFFER -- requirements
Module: udp_rx_pkt_buffer

---
 rtl/udp_rx_pkt_buffer.sv | 161 ++++++++++++++++
 tb/tb_udp_rx_pkt_buffer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/udp_rx_pkt_buffer.sv
// Receive-side packet buffer: stores UDP payload words, commits whole packets and streams them out.
// Optional statistics counters are enabled by defining UDP_RX_BUF_STATS_EN.
module udp_rx_pkt_buffer #(
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter int unsigned PKTQ_LOG2  = 3
) (
  input  logic        gmii_rx_clk,
  input  logic        rstn,
  input  logic        udp_rx_en,
  input  logic [31:0] udp_rx_data,
  input  logic        udp_rx_done,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic [15:0] drop_cnt,
  output logic [15:0] pkt_cnt
);

  localparam int unsigned Depth   = 2 ** DEPTH_LOG2;
  localparam int unsigned PqDepth = 2 ** PKTQ_LOG2;
  localparam int unsigned PtrW    = DEPTH_LOG2 + 1;
  localparam int unsigned PqW     = PKTQ_LOG2 + 1;
  localparam logic [PtrW-1:0] FullFill = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [PqW-1:0]  PqFull   = {1'b1, {PKTQ_LOG2{1'b0}}};

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  logic [31:0]     mem [Depth];
  logic [PtrW-1:0] pq_mem [PqDepth];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] wr_commit_q, wr_commit_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wcnt_q, wcnt_d;
  logic [PtrW-1:0] rem_q, rem_d;
  logic            ovf_q, ovf_d;
  logic [PqW-1:0]  pq_wr_q, pq_rd_q;
  state_e          state_q, state_d;

  logic [PtrW-1:0] fill, wptr_eff, wcnt_eff;
  logic            buf_full, wr_accept, ovf_eff;
  logic            pq_full, pq_empty, pq_pop;
  logic            commit, drop;

  // A word arriving together with udp_rx_done belongs to the ending packet.
  always_comb begin
    fill      = wr_ptr_q - rd_ptr_q;
    buf_full  = (fill == FullFill);
    wr_accept = udp_rx_en & ~buf_full;
    ovf_eff   = ovf_q | (udp_rx_en & buf_full);
    wptr_eff  = wr_ptr_q + PtrW'(wr_accept);
    wcnt_eff  = wcnt_q + PtrW'(wr_accept);
    pq_full   = ((pq_wr_q - pq_rd_q) == PqFull);
    pq_empty  = (pq_wr_q == pq_rd_q);
    commit    = udp_rx_done & ~ovf_eff & (wcnt_eff != '0) & ~pq_full;
    drop      = udp_rx_done & (ovf_eff | ((wcnt_eff != '0) & pq_full));
  end

  always_comb begin
    wr_ptr_d    = wptr_eff;
    wr_commit_d = wr_commit_q;
    ovf_d       = ovf_eff;
    wcnt_d      = wcnt_eff;
    if (udp_rx_done) begin
      ovf_d  = 1'b0;
      wcnt_d = '0;
      if (commit) begin
        wr_commit_d = wptr_eff;
      end else if (drop) begin
        wr_ptr_d = wr_commit_q;
      end
    end
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (wr_accept) begin
      mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= udp_rx_data;
    end
    if (commit) begin
      pq_mem[pq_wr_q[PKTQ_LOG2-1:0]] <= wcnt_eff;
    end
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    rd_ptr_d  = rd_ptr_q;
    pq_pop    = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    unique case (state_q)
      StIdle: begin
        if (!pq_empty) begin
          pq_pop  = 1'b1;
          rem_d   = pq_mem[pq_rd_q[PKTQ_LOG2-1:0]];
          state_d = StStream;
        end
      end
      StStream: begin
        out_valid = 1'b1;
        out_last  = (rem_q == PtrW'(1));
        out_data  = mem[rd_ptr_q[DEPTH_LOG2-1:0]];
        if (out_ready) begin
          rd_ptr_d = rd_ptr_q + PtrW'(1);
          rem_d    = rem_q - PtrW'(1);
          if (rem_q == PtrW'(1)) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge gmii_rx_clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      wcnt_q      <= '0;
      rem_q       <= '0;
      ovf_q       <= 1'b0;
      pq_wr_q     <= '0;
      pq_rd_q     <= '0;
      state_q     <= StIdle;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      wcnt_q      <= wcnt_d;
      rem_q       <= rem_d;
      ovf_q       <= ovf_d;
      state_q     <= state_d;
      if (commit) pq_wr_q <= pq_wr_q + PqW'(1);
      if (pq_pop) pq_rd_q <= pq_rd_q + PqW'(1);
    end
  end

`ifdef UDP_RX_BUF_STATS_EN
  logic [15:0] drop_cnt_q, pkt_cnt_q;

  always_ff @(posedge gmii_rx_clk or negedge rstn) begin
    if (!rstn) begin
      drop_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
      if (commit && (pkt_cnt_q != 16'hFFFF)) pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign pkt_cnt  = pkt_cnt_q;
`else
  assign drop_cnt = '0;
  assign pkt_cnt  = '0;
`endif

endmodule

// File: tb/tb_udp_rx_pkt_buffer.sv
// Directed bench for udp_rx_pkt_buffer built with a 16-word store and an 8-entry packet queue.
`define CHK(TAG, OBS, EXP) \
  begin \
    checks++; \
    assert ((OBS) === (EXP)) else begin \
      failures++; \
      $error("FAIL %s observed=%0h expected=%0h", TAG, OBS, EXP); \
    end \
  end

module tb_udp_rx_pkt_buffer;

`ifdef UDP_RX_BUF_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        udp_rx_en;
  logic [31:0] udp_rx_data;
  logic        udp_rx_done;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic [15:0] drop_cnt;
  logic [15:0] pkt_cnt;

  int checks = 0;
  int failures = 0;

  logic [31:0] got_data[$];
  bit          got_last[$];
  int          stab_err = 0;
  int          valid_cycles = 0;
  bit          stall_prev = 1'b0;
  logic [31:0] held_data;
  logic        held_last;

  udp_rx_pkt_buffer #(
    .DEPTH_LOG2(4),
    .PKTQ_LOG2 (3)
  ) dut (
    .gmii_rx_clk(clk),
    .rstn       (rstn),
    .udp_rx_en  (udp_rx_en),
    .udp_rx_data(udp_rx_data),
    .udp_rx_done(udp_rx_done),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .drop_cnt   (drop_cnt),
    .pkt_cnt    (pkt_cnt)
  );

  always #5 clk = ~clk;

  // Inputs move 1ns after the rising edge, so the falling edge sees what the next edge samples.
  always @(negedge clk) begin
    if (out_valid) valid_cycles++;
    if (stall_prev && (!out_valid || out_data !== held_data || out_last !== held_last)) begin
      stab_err++;
    end
    stall_prev = out_valid && !out_ready;
    held_data  = out_data;
    held_last  = out_last;
    if (out_valid && out_ready) begin
      got_data.push_back(out_data);
      got_last.push_back(out_last);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int n, input logic [31:0] base, input bit with_done);
    for (int i = 0; i < n; i++) begin
      udp_rx_en   = 1'b1;
      udp_rx_data = base + 32'(i);
      udp_rx_done = with_done && (i == n - 1);
      tick();
    end
    udp_rx_en   = 1'b0;
    udp_rx_done = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int cyc = 0;
    while (got_data.size() < n && cyc < 200) begin
      tick();
      cyc++;
    end
    `CHK("beat_count", got_data.size(), n)
  endtask

  task automatic clear_got();
    got_data.delete();
    got_last.delete();
  endtask

  initial begin
    logic [15:0] lmask;
    rstn        = 1'b0;
    udp_rx_en   = 1'b0;
    udp_rx_data = '0;
    udp_rx_done = 1'b0;
    out_ready   = 1'b0;
    repeat (3) tick();
    `CHK("rst_valid", out_valid, 1'b0)
    `CHK("rst_last", out_last, 1'b0)
    `CHK("rst_data", out_data, 32'h0)
    `CHK("rst_drop", drop_cnt, 16'h0)
    `CHK("rst_pkt", pkt_cnt, 16'h0)
    rstn = 1'b1;
    tick();

    // Four-word packet, consumer always ready.
    out_ready = 1'b1;
    clear_got();
    send_pkt(4, 32'hA000_0001, 1'b1);
    `CHK("lat_early", out_valid, 1'b0)
    tick();
    `CHK("lat_valid", out_valid, 1'b1)
    `CHK("lat_data", out_data, 32'hA000_0001)
    wait_beats(4);
    for (int i = 0; i < 4; i++) begin
      `CHK("p1_data", got_data[i], 32'hA000_0001 + 32'(i))
      `CHK("p1_last", got_last[i], (i == 3))
    end
    `CHK("p1_pkt", pkt_cnt, Stats ? 16'd1 : 16'd0)

    // 20-word packet overflows the 16-word store and must vanish.
    out_ready    = 1'b0;
    clear_got();
    valid_cycles = 0;
    send_pkt(20, 32'hB000_0000, 1'b1);
    repeat (5) tick();
    `CHK("ovf_valid_cycles", valid_cycles, 0)
    `CHK("ovf_drop", drop_cnt, Stats ? 16'd1 : 16'd0)
    `CHK("ovf_pkt", pkt_cnt, Stats ? 16'd1 : 16'd0)
    out_ready = 1'b1;
    send_pkt(3, 32'hC000_0000, 1'b1);
    wait_beats(3);
    for (int i = 0; i < 3; i++) begin
      `CHK("p3_data", got_data[i], 32'hC000_0000 + 32'(i))
      `CHK("p3_last", got_last[i], (i == 2))
    end
    `CHK("p3_pkt", pkt_cnt, Stats ? 16'd2 : 16'd0)

    // Nine 2-word packets while stalled: eight fill the store, the ninth is dropped.
    out_ready = 1'b0;
    tick();
    clear_got();
    for (int k = 0; k < 9; k++) begin
      send_pkt(2, 32'hD000_0000 + 32'(2 * k), 1'b1);
    end
    tick();
    `CHK("q_drop", drop_cnt, Stats ? 16'd2 : 16'd0)
    `CHK("q_pkt", pkt_cnt, Stats ? 16'd10 : 16'd0)
    out_ready = 1'b1;
    wait_beats(16);
    repeat (10) tick();
    `CHK("q_total", got_data.size(), 16)
    lmask = '0;
    for (int i = 0; i < 16; i++) begin
      `CHK("q_data", got_data[i], 32'hD000_0000 + 32'(i))
      lmask[i] = got_last[i];
    end
    `CHK("q_last_mask", lmask, 16'hAAAA)

    // Six-word packet drained with out_ready toggling every cycle.
    out_ready = 1'b0;
    clear_got();
    stab_err = 0;
    send_pkt(6, 32'hE000_0000, 1'b1);
    for (int c = 0; c < 60 && got_data.size() < 6; c++) begin
      out_ready = ~out_ready;
      tick();
    end
    out_ready = 1'b1;
    repeat (5) tick();
    `CHK("tog_count", got_data.size(), 6)
    for (int i = 0; i < 6 && i < got_data.size(); i++) begin
      `CHK("tog_data", got_data[i], 32'hE000_0000 + 32'(i))
      `CHK("tog_last", got_last[i], (i == 5))
    end
    `CHK("tog_stable", stab_err, 0)

    // Reset in the middle of a 5-word packet.
    clear_got();
    send_pkt(2, 32'hF000_0001, 1'b0);
    rstn = 1'b0;
    #2;
    `CHK("mid_rst_valid", out_valid, 1'b0)
    `CHK("mid_rst_last", out_last, 1'b0)
    `CHK("mid_rst_data", out_data, 32'h0)
    `CHK("mid_rst_drop", drop_cnt, 16'h0)
    `CHK("mid_rst_pkt", pkt_cnt, 16'h0)
    tick();
    rstn = 1'b1;
    tick();
    send_pkt(3, 32'h9000_0001, 1'b1);
    wait_beats(3);
    repeat (10) tick();
    `CHK("post_rst_count", got_data.size(), 3)
    for (int i = 0; i < 3 && i < got_data.size(); i++) begin
      `CHK("post_rst_data", got_data[i], 32'h9000_0001 + 32'(i))
      `CHK("post_rst_last", got_last[i], (i == 2))
    end
    `CHK("post_rst_pkt", pkt_cnt, Stats ? 16'd1 : 16'd0)
    `CHK("post_rst_drop", drop_cnt, 16'h0)

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
